// File: rtl/mvm_par.sv
// Matrix-vector multiplier y = A*x with P parallel MAC lanes.
// A and x are loaded word-serially, then y streams out one word per cycle.
module mvm_par #(
    parameter int M    = 32,
    parameter int N    = 32,
    parameter int P    = 1,
    parameter int T    = 8,
    parameter int OW   = 2*T,
    parameter int SAT  = 0,
    parameter int RELU = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 loadMatrix,
    input  logic                 loadVector,
    input  logic                 start,
    input  logic signed [T-1:0]  data_in,
    output logic                 done,
    output logic                 out_valid,
    output logic                 busy,
    output logic signed [OW-1:0] data_out,
    output logic [2:0]           state_dbg
);
    localparam int AW  = 2*T + $clog2(N);
    localparam int XW  = AW + OW + 1;
    localparam int G   = M / P;
    localparam int K   = G * N;
    localparam int AIW = (M*N > 1) ? $clog2(M*N) : 1;
    localparam int XIW = (N > 1) ? $clog2(N) : 1;
    localparam int YIW = (M > 1) ? $clog2(M) : 1;
    localparam int GW  = (G > 1) ? $clog2(G) : 1;
    localparam int CW  = $clog2(K + 2);
    localparam int OIW = $clog2(M + 1);

    localparam logic [AIW-1:0] MN_LAST = AIW'(M*N - 1);
    localparam logic [AIW-1:0] N_LAST  = AIW'(N - 1);
    localparam logic [XIW-1:0] COL_LAST = XIW'(N - 1);
    localparam logic [CW-1:0]  K_ISSUE = CW'(K);
    localparam logic [CW-1:0]  K_END   = CW'(K + 1);
    localparam logic [OIW-1:0] O_END   = OIW'(M);
    localparam logic signed [XW-1:0] S_MAX = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [XW-1:0] S_MIN = ~S_MAX;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_X, S_COMPUTE, S_DONE, S_OUTPUT
    } state_t;

    state_t state;
    logic   m_ok, v_ok;
    logic [AIW-1:0] ld_cnt;
    logic [CW-1:0]  cnt;
    logic [XIW-1:0] col;
    logic [GW-1:0]  grp;
    logic [OIW-1:0] out_idx;

    logic signed [T-1:0]    a_mem [M*N];
    logic signed [T-1:0]    x_mem [N];
    logic signed [OW-1:0]   y_mem [M];

    logic [AIW-1:0]         a_idx  [P];
    logic signed [2*T-1:0]  mul    [P];
    logic signed [2*T-1:0]  prod   [P];
    logic signed [AW-1:0]   acc    [P];
    logic signed [AW-1:0]   acc_nx [P];
    logic                   p_vld, p_first, p_last;
    logic [GW-1:0]          p_grp;

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // ReLU is applied first, then either clamp or keep the low OW bits.
    function automatic logic signed [OW-1:0] post(input logic signed [AW-1:0] v);
        logic signed [XW-1:0] w;
        w = XW'(v);
        if (RELU != 0 && w[XW-1]) w = '0;
        if (SAT != 0) begin
            if (w > S_MAX)      w = S_MAX;
            else if (w < S_MIN) w = S_MIN;
        end
        return w[OW-1:0];
    endfunction

    always_comb begin
        for (int l = 0; l < P; l++) begin
            a_idx[l]  = AIW'((int'(grp) * P + l) * N + int'(col));
            mul[l]    = (2*T)'(a_mem[a_idx[l]]) * (2*T)'(x_mem[col]);
            acc_nx[l] = (p_first ? '0 : acc[l]) + AW'(prod[l]);
        end
    end

    // Storage carries no reset; the loaded flags alone say whether it is valid.
    always_ff @(posedge clk) begin
        if (state == S_LOAD_A) a_mem[ld_cnt] <= data_in;
        if (state == S_LOAD_X) x_mem[XIW'(ld_cnt)] <= data_in;
        if (p_vld && p_last) begin
            for (int l = 0; l < P; l++) y_mem[YIW'(int'(p_grp) * P + l)] <= post(acc_nx[l]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            m_ok      <= 1'b0;
            v_ok      <= 1'b0;
            ld_cnt    <= '0;
            cnt       <= '0;
            col       <= '0;
            grp       <= '0;
            out_idx   <= '0;
            p_vld     <= 1'b0;
            p_first   <= 1'b0;
            p_last    <= 1'b0;
            p_grp     <= '0;
            for (int l = 0; l < P; l++) begin
                prod[l] <= '0;
                acc[l]  <= '0;
            end
        end else begin
            p_vld <= 1'b0;
            if (p_vld) begin
                for (int l = 0; l < P; l++) acc[l] <= acc_nx[l];
            end
            case (state)
                S_IDLE: begin
                    ld_cnt <= '0;
                    if (loadMatrix) begin
                        state <= S_LOAD_A;
                        m_ok  <= 1'b0;
                    end else if (loadVector) begin
                        state <= S_LOAD_X;
                        v_ok  <= 1'b0;
                    end else if (start && m_ok && v_ok) begin
                        state <= S_COMPUTE;
                        cnt   <= '0;
                        col   <= '0;
                        grp   <= '0;
                    end
                end
                S_LOAD_A: begin
                    ld_cnt <= ld_cnt + 1'b1;
                    if (ld_cnt == MN_LAST) begin
                        state <= S_IDLE;
                        m_ok  <= 1'b1;
                    end
                end
                S_LOAD_X: begin
                    ld_cnt <= ld_cnt + 1'b1;
                    if (ld_cnt == N_LAST) begin
                        state <= S_IDLE;
                        v_ok  <= 1'b1;
                    end
                end
                S_COMPUTE: begin
                    cnt <= cnt + 1'b1;
                    // Issue K column steps, then two cycles drain multiply and accumulate.
                    if (cnt < K_ISSUE) begin
                        p_vld   <= 1'b1;
                        p_first <= (col == '0);
                        p_last  <= (col == COL_LAST);
                        p_grp   <= grp;
                        for (int l = 0; l < P; l++) prod[l] <= mul[l];
                        if (col == COL_LAST) begin
                            col <= '0;
                            grp <= grp + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                    if (cnt == K_END) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state     <= S_OUTPUT;
                    done      <= 1'b0;
                    out_valid <= 1'b1;
                    data_out  <= y_mem[0];
                    out_idx   <= OIW'(1);
                end
                S_OUTPUT: begin
                    if (out_idx == O_END) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        data_out  <= '0;
                    end else begin
                        data_out <= y_mem[YIW'(out_idx)];
                        out_idx  <= out_idx + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
